// File: rtl/rot_shift_arbiter_if.sv
// rot_shift_arbiter_if: request/response bundle between the shift issuers and the shared rotator
interface rot_shift_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [3*NUM_REQ-1:0]      req_op;
   logic [DATA_W*NUM_REQ-1:0] req_data;
   logic [5*NUM_REQ-1:0]      req_amt;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [DATA_W-1:0]         resp_data;
   logic [ID_W-1:0]           resp_id;
   logic                      resp_err;

   modport master (
      output req_valid, req_op, req_data, req_amt, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_data, req_amt, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id, resp_err
   );
endinterface

// File: rtl/rot_shift_arbiter.sv
// rot_shift_arbiter: round-robin share of one 32-bit rotator; ROL/SHR/SHL/SHRA derived from ROR plus masking.
// Optional ROT_OPCOUNT_EN adds a saturating 16-bit count of completed responses (op_count).
module rot_shift_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1,
   parameter int DATA_W  = 32
) (
   input logic                clock,
   input logic                clear,
   rot_shift_arbiter_if.slave bus
`ifdef ROT_OPCOUNT_EN
   ,
   output logic [15:0]        op_count
`endif
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam logic [2:0] OP_ROR  = 3'd0;
   localparam logic [2:0] OP_ROL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_SHL  = 3'd3;
   localparam logic [2:0] OP_SHRA = 3'd4;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr, win, cand;
   logic                any_valid, hs;
   logic [2:0]          sel_op, op_q;
   logic [DATA_W-1:0]   sel_data, data_q;
   logic [4:0]          sel_amt, amt_q, rot_amt;
   logic [ID_W-1:0]     id_q;
   logic [2*DATA_W-1:0] rot_wide;
   logic [DATA_W-1:0]   rot, hi_mask, lo_mask, result;
   logic                err;
   logic [DATA_W-1:0]   resp_data_q;
   logic                resp_err_q;

   // Round-robin pick: first valid index at or after rr, plus a mux of that requester's operands
   always_comb begin
      win       = rr;
      cand      = rr;
      any_valid = 1'b0;
      sel_op    = '0;
      sel_data  = '0;
      sel_amt   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ID_W'((int'(rr) + k) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            win       = cand;
            any_valid = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == ID_W'(i)) begin
            sel_op   = bus.req_op[3*i +: 3];
            sel_data = bus.req_data[DATA_W*i +: DATA_W];
            sel_amt  = bus.req_amt[5*i +: 5];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clock or posedge clear) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state and handshake outputs; grant is suppressed while clear is asserted
   always_comb begin
      state_nxt      = state;
      hs             = 1'b0;
      bus.req_ready  = '0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            hs            = any_valid && !clear;
            bus.req_ready = hs ? NUM_REQ'(1) << win : '0;
            state_nxt     = hs ? EXEC : IDLE;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            bus.resp_valid = 1'b1;
            state_nxt      = bus.resp_ready ? IDLE : RESP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture at the request handshake and round-robin pointer advance past the winner
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         rr     <= '0;
         op_q   <= '0;
         data_q <= '0;
         amt_q  <= '0;
         id_q   <= '0;
      end else if (hs) begin
         rr     <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         op_q   <= sel_op;
         data_q <= sel_data;
         amt_q  <= sel_amt;
         id_q   <= win;
      end
   end

   // Shared rotator: left rotations become right rotations by (32-a) mod 32, shifts mask the wrapped bits
   always_comb begin
      rot_amt  = (op_q == OP_ROL || op_q == OP_SHL) ? 5'd0 - amt_q : amt_q;
      rot_wide = {data_q, data_q} >> rot_amt;
      rot      = rot_wide[DATA_W-1:0];
      hi_mask  = ~({DATA_W{1'b1}} >> amt_q);
      lo_mask  = ~({DATA_W{1'b1}} << amt_q);
      err      = op_q > OP_SHRA;
      result   = (op_q == OP_ROR || op_q == OP_ROL) ? rot :
                 (op_q == OP_SHR)  ? rot & ~hi_mask :
                 (op_q == OP_SHL)  ? rot & ~lo_mask :
                 (op_q == OP_SHRA) ? (data_q[DATA_W-1] ? rot | hi_mask : rot & ~hi_mask) :
                 data_q;
   end

   // Result register, loaded once in EXEC and held through RESP
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else if (state == EXEC) begin
         resp_data_q <= result;
         resp_err_q  <= err;
      end
   end

   assign bus.resp_data = resp_data_q;
   assign bus.resp_err  = resp_err_q;
   assign bus.resp_id   = id_q;

`ifdef ROT_OPCOUNT_EN
   // Saturating count of completed response handshakes, illegal ops included
   always_ff @(posedge clock or posedge clear) begin
      if (clear)                                                         op_count <= '0;
      else if (state == RESP && bus.resp_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_rot_shift_arbiter.sv
// tb_rot_shift_arbiter: scoreboard bench for rot_shift_arbiter with an independent shift/rotate model
module tb_rot_shift_arbiter;
   typedef struct {
      logic [31:0] data;
      logic [0:0]  id;
      logic        err;
   } exp_t;

   logic clock = 1'b0;
   logic clear;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];
   logic [0:0] rr_m;
   logic busy_m, prev_rv, b2b, have_last;
   int   hs_cyc, last_hs, hs_n, cnt_m;

   rot_shift_arbiter_if #(.NUM_REQ(2), .ID_W(1), .DATA_W(32)) bus ();
`ifdef ROT_OPCOUNT_EN
   logic [15:0] op_count;
`endif

   rot_shift_arbiter #(.NUM_REQ(2), .ID_W(1), .DATA_W(32)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
`ifdef ROT_OPCOUNT_EN
      ,
      .op_count (op_count)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a, input logic [0:0] id);
      exp_t e;
      logic [31:0] r;
      logic signed [31:0] s;
      r = d;
      s = d;
      case (op)
         3'd0: for (int k = 0; k < 32; k++) if (k < int'(a)) r = {r[0], r[31:1]};
         3'd1: for (int k = 0; k < 32; k++) if (k < int'(a)) r = {r[30:0], r[31]};
         3'd2: r = d >> a;
         3'd3: r = d << a;
         3'd4: r = s >>> a;
         default: r = d;
      endcase
      e.data = r;
      e.id   = id;
      e.err  = op > 3'd4;
      return e;
   endfunction

   // Monitor: models grant, scoreboard push at request handshake, pop and compare at response handshake
   always @(negedge clock) begin
      exp_t e;
      logic [0:0] ew;
      logic [1:0] exp_ready;
      if (clear) begin
         check("ready_in_clear", {30'd0, bus.req_ready}, 0);
         sb.delete();
         rr_m    = 1'b0;
         busy_m  = 1'b0;
         prev_rv = 1'b0;
         cnt_m   = 0;
      end else begin
         if (bus.resp_valid && !prev_rv) check("latency", cyc - hs_cyc, 2);
         prev_rv   = bus.resp_valid;
         ew        = bus.req_valid[rr_m] ? rr_m : ~rr_m;
         exp_ready = (!busy_m && |bus.req_valid) ? (2'b01 << ew) : 2'b00;
         check("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_ready});
         if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) check("unexpected_resp", 1, 0);
            else begin
               e = sb.pop_front();
               check("resp_data", bus.resp_data, e.data);
               check("resp_id", {31'd0, bus.resp_id}, {31'd0, e.id});
               check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
               cnt_m++;
            end
            busy_m = 1'b0;
         end
         if (exp_ready != 2'b00) begin
            sb.push_back(model(bus.req_op[3*ew +: 3], bus.req_data[32*ew +: 32], bus.req_amt[5*ew +: 5], ew));
            busy_m = 1'b1;
            hs_cyc = cyc;
            rr_m   = ~ew;
            if (b2b) begin
               if (have_last) check("b2b_gap", cyc - last_hs, 3);
               have_last = 1'b1;
               last_hs   = cyc;
               hs_n++;
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
      bus.req_op[3*i +: 3]   = op;
      bus.req_data[32*i +: 32] = d;
      bus.req_amt[5*i +: 5]  = a;
      bus.req_valid[i]       = 1'b1;
   endtask

   task automatic issue(input int i, input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
      logic got;
      got = 1'b0;
      set_req(i, op, d, a);
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clock);
         got = bus.req_ready[i];
      end
      if (!got) check("grant_timeout", 0, 1);
      @(posedge clock);
      #1;
      bus.req_valid[i] = 1'b0;
      set_req(i, 3'($urandom_range(7)), $urandom, 5'($urandom_range(31)));
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && busy_m; t++) begin
         @(posedge clock);
         #1;
      end
      check("drain", {31'd0, busy_m}, 0);
   endtask

   initial begin
      b2b = 0; have_last = 0; hs_n = 0; hs_cyc = 0; last_hs = 0;
      busy_m = 0; prev_rv = 0; rr_m = 0; cnt_m = 0;
      bus.req_op = '0; bus.req_data = '0; bus.req_amt = '0;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      clear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 0);
      check("rst_resp_data", bus.resp_data, 0);
      check("rst_resp_id", {31'd0, bus.resp_id}, 0);
      check("rst_resp_err", {31'd0, bus.resp_err}, 0);
      check("rst_req_ready", {30'd0, bus.req_ready}, 0);
      bus.req_valid = 2'b00;
      clear = 1'b0;
      @(posedge clock);
      #1;
      issue(0, 3'd0, 32'h00000001, 5'd1);
      drain();
      issue(1, 3'd4, 32'h80000000, 5'd4);
      drain();
      issue(1, 3'd2, 32'h80000000, 5'd4);
      drain();
      issue(1, 3'd3, 32'h0000000F, 5'd8);
      drain();
      issue(1, 3'd1, 32'h80000001, 5'd1);
      drain();
      issue(0, 3'd2, 32'hDEADBEEF, 5'd0);
      drain();
      // both requesters held: grants alternate, one op per 3 cycles
      have_last = 0;
      hs_n = 0;
      b2b = 1;
      set_req(0, 3'd0, 32'h0000F00D, 5'd3);
      set_req(1, 3'd3, 32'hA5A5A5A5, 5'd31);
      repeat (13) @(posedge clock);
      #1;
      bus.req_valid = 2'b00;
      drain();
      b2b = 0;
      check("b2b_count", {31'd0, hs_n >= 4}, 1);
      // response held off: outputs stable, nobody else granted
      bus.resp_ready = 1'b0;
      issue(0, 3'd4, 32'hC0000000, 5'd7);
      for (int t = 0; t < 10 && !bus.resp_valid; t++) @(posedge clock);
      #1;
      set_req(1, 3'd1, 32'h12345678, 5'd16);
      repeat (5) begin
         @(negedge clock);
         check("hold_valid", {31'd0, bus.resp_valid}, 1);
         check("hold_data", bus.resp_data, sb[0].data);
         check("hold_id", {31'd0, bus.resp_id}, {31'd0, sb[0].id});
      end
      @(posedge clock);
      #1;
      bus.resp_ready = 1'b1;
      @(posedge clock);
      #1;
      check("idle_after_resp", {31'd0, bus.resp_valid}, 0);
      for (int t = 0; t < 10 && !bus.req_ready[1]; t++) @(negedge clock);
      @(posedge clock);
      #1;
      bus.req_valid = 2'b00;
      drain();
      // clear in EXEC discards the op and resets the pointer
      issue(1, 3'd0, 32'h87654321, 5'd9);
      clear = 1'b1;
      #1;
      check("clr_resp_valid", {31'd0, bus.resp_valid}, 0);
      @(negedge clock);
      @(posedge clock);
      #1;
      clear = 1'b0;
      set_req(0, 3'd2, 32'hFFFF0000, 5'd12);
      set_req(1, 3'd3, 32'h0000FFFF, 5'd12);
      @(negedge clock);
      check("post_clr_grant", {30'd0, bus.req_ready}, 2'b01);
      @(posedge clock);
      #1;
      bus.req_valid = 2'b00;
      drain();
      issue(1, 3'd7, 32'h12345678, 5'd3);
      drain();
      issue(0, 3'd5, 32'hCAFEF00D, 5'd0);
      drain();
      for (int n = 0; n < 20; n++) begin
         issue(int'($urandom_range(1)), 3'($urandom_range(7)), $urandom, 5'($urandom_range(31)));
         drain();
      end
`ifdef ROT_OPCOUNT_EN
      check("op_count", {16'd0, op_count}, 32'(cnt_m));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
